seq_detect_prog: RTL and testbench

//  Programmable serial bit-sequence detector; successor to the fixed 4-bit "1011" FSM detector.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/seq_match_counter.sv | 20 ++
 rtl/seq_detect_prog.sv | 102 ++++++++++
 tb/tb_seq_detect_prog.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants for the programmable sequence detector: default pattern, length and overlap mode,
// plus the helper that sizes the length fields.
package seq_detect_pkg;

    localparam int                   SEQ_MAX_LEN     = 8;
    localparam int                   SEQ_DEF_LEN     = 4;
    localparam logic [SEQ_MAX_LEN-1:0] SEQ_DEF_PATTERN = 8'h0B;
    localparam bit                   SEQ_DEF_OVERLAP = 1'b1;

    // Bits needed to hold a length in 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter. Clear wins over a simultaneous increment; holds at all-ones.
module seq_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector with run-time pattern/length/overlap configuration.
// Optional saturating match counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = SEQ_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
    parameter int                 DEF_LEN     = SEQ_DEF_LEN,
    parameter bit                 DEF_OVERLAP = SEQ_DEF_OVERLAP,
    parameter int                 CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        inp_bit,
    input  logic                        cfg_wr,
    input  logic [MAX_LEN-1:0]          cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
    input  logic                        cfg_overlap,
    output logic                        cfg_err,
    output logic                        seq_seen,
    output logic [CNT_W-1:0]            match_cnt,
    input  logic                        cnt_clr
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_n;
    logic               cfg_ok;
    logic               shift_en;
    logic               match;

    // in_valid qualifies inp_bit on each edge; there is no ready, every qualified bit is consumed
    // unless a valid cfg_wr on the same edge takes priority and drops it.
    always_comb begin
        cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        shift_en = in_valid && !(cfg_wr && cfg_ok);
        hist_n   = {hist[MAX_LEN-2:0], inp_bit};
        fill_n   = (fill == len) ? len : fill + LEN_W'(1);
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        match    = shift_en && (fill_n == len) && ((hist_n & mask) == (pattern & mask));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist     <= '0;
            fill     <= '0;
            pattern  <= DEF_PATTERN;
            len      <= LEN_W'(DEF_LEN);
            overlap  <= DEF_OVERLAP;
            seq_seen <= 1'b0;
            cfg_err  <= 1'b0;
        end else if (cfg_wr && cfg_ok) begin
            hist     <= '0;
            fill     <= '0;
            pattern  <= cfg_pattern;
            len      <= cfg_len;
            overlap  <= cfg_overlap;
            seq_seen <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err  <= cfg_wr;
            seq_seen <= match;
            if (shift_en) begin
                hist <= hist_n;
                // Non-overlapping mode demands len fresh bits before the next match.
                fill <= (match && !overlap) ? '0 : fill_n;
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    logic cnt_clear;
    assign cnt_clear = cnt_clr || (cfg_wr && cfg_ok);

    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_match_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (match),
        .clr  (cnt_clear),
        .count(match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus randomized traffic against a
// bit-history reference model. Counter checks adapt to SEQ_DETECT_CNT_EN.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;
`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         inp_bit;
    logic         cfg_wr;
    logic [7:0]   cfg_pattern;
    logic [3:0]   cfg_len;
    logic         cfg_overlap;
    logic         cfg_err;
    logic         seq_seen;
    logic [1:0]   match_cnt;
    logic         cnt_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: pattern config, recent valid bits, bits since the last fill restart.
    logic [7:0]   m_pat;
    int           m_len;
    logic         m_ovl;
    logic         bit_q[$];
    int           m_since;
    logic         m_seen;
    logic         m_err;
    int           m_cnt;
    logic [3:0]   exp_q[$];

    seq_detect_prog #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .inp_bit    (inp_bit),
        .cfg_wr     (cfg_wr),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_err    (cfg_err),
        .seq_seen   (seq_seen),
        .match_cnt  (match_cnt),
        .cnt_clr    (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        logic hit;
        if (reset) begin
            m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
            bit_q.delete(); m_since = 0; m_seen = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else if (cfg_wr && (cfg_len >= 1) && (cfg_len <= MAX_LEN)) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            bit_q.delete(); m_since = 0; m_seen = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            m_err  = cfg_wr;
            m_seen = 1'b0;
            if (in_valid) begin
                bit_q.push_back(inp_bit);
                if (bit_q.size() > MAX_LEN) void'(bit_q.pop_front());
                m_since++;
                if (m_since >= m_len) begin
                    // Oldest of the last m_len bits must equal pattern[m_len-1].
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (bit_q[bit_q.size() - m_len + k] !== m_pat[m_len - 1 - k]) hit = 1'b0;
                    end
                    if (hit) begin
                        m_seen = 1'b1;
                        if (!m_ovl) m_since = 0;
                    end
                end
            end
            if (CNT_EN) begin
                if (cnt_clr) m_cnt = 0;
                else if (m_seen && (m_cnt < CNT_MAX)) m_cnt++;
            end
        end
        exp_q.push_back({2'(m_cnt), m_err, m_seen});
    endtask

    task automatic tick(output logic [3:0] obs, output logic [3:0] exp);
        @(posedge clk);
        model_step();
        #1;
        obs = {match_cnt, cfg_err, seq_seen};
        exp = exp_q.pop_front();
    endtask

    task automatic apply(input logic v, input logic b, input logic w, input logic [7:0] p,
                         input logic [3:0] l, input logic o, input logic c,
                         output logic [3:0] obs, output logic [3:0] exp);
        in_valid = v; inp_bit = b; cfg_wr = w; cfg_pattern = p; cfg_len = l;
        cfg_overlap = o; cnt_clr = c;
        tick(obs, exp);
        in_valid = 1'b0; cfg_wr = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic send_bit(input logic b, output logic [3:0] obs, output logic [3:0] exp);
        apply(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, obs, exp);
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                            output logic [3:0] obs, output logic [3:0] exp);
        apply(1'b0, 1'b0, 1'b1, p, l, o, 1'b0, obs, exp);
    endtask

    task automatic test_reset();
        logic [3:0] obs, exp;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(obs, exp);
            checks++;
            if (obs !== 4'b0000) begin
                errors++; $display("FAIL reset_outputs got %b want %b", obs, 4'b0000);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_default();
        logic [3:0] obs, exp;
        logic [3:0] stream = 4'b1011;
        int pulses = 0;
        for (int i = 3; i >= 0; i--) begin
            send_bit(stream[i], obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL default_bit%0d got %b want %b", i, obs, exp); end
            if (obs[0]) pulses++;
        end
        checks++;
        if (obs[0] !== 1'b1) begin errors++; $display("FAIL default_last_pulse got %b want 1", obs[0]); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL default_pulses got %0d want 1", pulses); end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, obs, exp);
        checks++;
        if (obs[0] !== 1'b0) begin errors++; $display("FAIL default_one_cycle got %b want 0", obs[0]); end
    endtask

    task automatic test_overlap();
        logic [3:0] obs, exp;
        logic [6:0] stream = 7'b1011011;
        int pulses;
        for (int mode = 1; mode >= 0; mode--) begin
            // 8'hFB exercises masking of pattern bits above len.
            load_cfg((mode == 1) ? 8'h0B : 8'hFB, 4'd4, mode[0], obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL overlap_cfg got %b want %b", obs, exp); end
            pulses = 0;
            for (int i = 6; i >= 0; i--) begin
                send_bit(stream[i], obs, exp);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL overlap%0d_bit%0d got %b want %b", mode, i, obs, exp); end
                if (obs[0]) pulses++;
            end
            checks++;
            if (pulses !== ((mode == 1) ? 2 : 1)) begin
                errors++; $display("FAIL overlap%0d_pulses got %0d want %0d", mode, pulses, (mode == 1) ? 2 : 1);
            end
        end
    endtask

    task automatic test_len8_gaps();
        logic [3:0] obs, exp;
        logic [7:0] stream;
        int pulses;
        for (int pass = 0; pass < 2; pass++) begin
            stream = (pass == 0) ? 8'hA5 : (8'hA5 ^ 8'h08);
            load_cfg(8'hA5, 4'd8, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL len8_cfg got %b want %b", obs, exp); end
            pulses = 0;
            for (int i = 7; i >= 0; i--) begin
                send_bit(stream[i], obs, exp);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL len8_p%0d_bit%0d got %b want %b", pass, i, obs, exp); end
                if (obs[0]) pulses++;
                apply(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, obs, exp);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL len8_p%0d_gap%0d got %b want %b", pass, i, obs, exp); end
                if (obs[0]) pulses++;
            end
            checks++;
            if (pulses !== ((pass == 0) ? 1 : 0)) begin
                errors++; $display("FAIL len8_p%0d_pulses got %0d want %0d", pass, pulses, (pass == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_bad_cfg();
        logic [3:0] obs, exp;
        logic [3:0] bad_len [2] = '{4'd0, 4'd9};
        int pulses, errs;
        load_cfg(8'h0B, 4'd4, 1'b1, obs, exp);
        for (int t = 0; t < 3; t++) begin
            pulses = 0; errs = 0;
            // t<2: rejected cfg_wr, its bit still shifts; t==2: accepted cfg_wr drops the bit.
            apply(1'b1, 1'b1, 1'b1, (t < 2) ? 8'h00 : 8'h0B, (t < 2) ? bad_len[t] : 4'd4, 1'b1, 1'b0, obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL badcfg%0d_wr got %b want %b", t, obs, exp); end
            if (obs[1]) errs++;
            for (int i = 2; i >= 0; i--) begin
                send_bit(i != 2, obs, exp);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL badcfg%0d_bit%0d got %b want %b", t, i, obs, exp); end
                if (obs[0]) pulses++;
                if (obs[1]) errs++;
            end
            checks++;
            if (errs !== ((t < 2) ? 1 : 0)) begin errors++; $display("FAIL badcfg%0d_err got %0d want %0d", t, errs, (t < 2) ? 1 : 0); end
            checks++;
            if (pulses !== ((t < 2) ? 1 : 0)) begin errors++; $display("FAIL badcfg%0d_pulses got %0d want %0d", t, pulses, (t < 2) ? 1 : 0); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        logic [4:0] stream = 5'b11011;
        int pulses = 0;
        send_bit(1'b1, obs, exp);
        send_bit(1'b0, obs, exp);
        send_bit(1'b1, obs, exp);
        reset = 1'b1;
        tick(obs, exp);
        reset = 1'b0;
        checks++;
        if (obs !== 4'b0000) begin errors++; $display("FAIL resetmid_clear got %b want 0000", obs); end
        for (int i = 4; i >= 0; i--) begin
            send_bit(stream[i], obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL resetmid_bit%0d got %b want %b", i, obs, exp); end
            if (obs[0]) begin
                pulses++;
                checks++;
                if (i !== 0) begin errors++; $display("FAIL resetmid_pulse_pos got %0d want 0", i); end
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL resetmid_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_counter();
        logic [3:0]  obs, exp;
        logic [15:0] stream = 16'b1011011011011011;
        int          want [5] = '{1, 2, 3, 3, 3};
        int          n = 0;
        logic [2:0]  tail = 3'b011;
        load_cfg(8'h0B, 4'd4, 1'b1, obs, exp);
        for (int i = 15; i >= 0; i--) begin
            send_bit(stream[i], obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL cnt_bit%0d got %b want %b", i, obs, exp); end
            if (obs[0]) begin
                checks++;
                if (int'(obs[3:2]) !== (CNT_EN ? want[n] : 0)) begin
                    errors++; $display("FAIL cnt_match%0d got %0d want %0d", n, obs[3:2], CNT_EN ? want[n] : 0);
                end
                if (n < 4) n++;
            end
        end
        for (int i = 2; i >= 0; i--) begin
            apply(1'b1, tail[i], 1'b0, 8'h00, 4'd0, 1'b0, i == 0, obs, exp);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL cnt_clr_bit%0d got %b want %b", i, obs, exp); end
        end
        checks++;
        if (obs !== 4'b0001) begin errors++; $display("FAIL cnt_clr_wins got %b want 0001", obs); end
    endtask

    task automatic test_random();
        logic [3:0] obs, exp;
        int r;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                reset = 1'b1;
                tick(obs, exp);
                reset = 1'b0;
            end else if (r < 4) begin
                apply($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 8'($urandom),
                      4'($urandom_range(0, 10)), $urandom_range(0, 1), 1'b0, obs, exp);
            end else begin
                apply($urandom_range(0, 3) != 0, $urandom_range(0, 1), 1'b0, 8'h00, 4'd0, 1'b0,
                      $urandom_range(0, 40) == 0, obs, exp);
            end
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL random_cyc%0d got %b want %b", cyc, obs, exp); end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; inp_bit = 1'b0; cfg_wr = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_default();
        test_overlap();
        test_len8_gaps();
        test_bad_cfg();
        test_reset_mid();
        test_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
